axi4_burst_mem_responder: RTL and testbench

AXI4 subordinate (responder) memory model that answers the manager-side traffic issued by AXI4MasterDevice instances through the NoC wrapper. It supports INCR bursts with independent write and read state machines, a programmable read wait-state, and decode/protocol error responses. It is used in testbenches at s0/s1 in place of simple slave devices, so that burst, backpressure and error paths can be checked end to end.

---
 rtl/axi4_burst_mem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_axi4_burst_mem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_mem_responder.sv
// AXI4 subordinate memory model: word-addressed INCR bursts with independent
// write and read FSMs, a programmable read wait-state, DECERR for bursts that
// run past the end of memory and SLVERR for wlast framing errors.
module axi4_burst_mem_responder #(
    parameter int DEPTH      = 256,
    parameter int READ_DELAY = 2,
    parameter int ID_W       = 4,
    parameter int DATA_W     = 64
) (
    input  logic              CLK,
    input  logic              RST,
    // write address channel
    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    // write data channel
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    // write response channel
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    // read address channel
    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
    // read data channel
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // status
    output logic [7:0]        err_count,
    output logic              busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    // A burst is out of range when its last word index reaches DEPTH; the
    // 33-bit sum keeps a wrap of the 32-bit address from looking legal.
    function automatic logic burst_decerr(input logic [31:0] addr, input logic [7:0] len);
        return ({1'b0, addr} + {25'd0, len}) >= 33'(DEPTH);
    endfunction

    // Saturating add of up to two error events onto the 8-bit counter.
    function automatic logic [7:0] err_sat_add(input logic [7:0] cnt, input logic a, input logic b);
        logic [9:0] sum;
        sum = {2'b00, cnt} + {9'd0, a} + {9'd0, b};
        return (sum > 10'd255) ? 8'hff : sum[7:0];
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // write-side state
    w_state_t   w_state;
    logic [AW-1:0] w_addr;
    logic [8:0] w_beats;
    logic [8:0] w_k;
    logic       w_dec;
    logic       w_last_beat;
    logic [AW-1:0] w_idx;
    logic       mem_we;

    // read-side state
    r_state_t   r_state;
    logic [AW-1:0] r_addr;
    logic [8:0] r_beats;
    logic [8:0] r_k;
    logic [8:0] r_k_nxt;
    logic       r_dec;
    logic [31:0] r_wait;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_idx_nxt;

    logic b_err_fire;
    logic r_err_fire;

    assign w_last_beat = (w_k == (w_beats - 9'd1));
    assign w_idx       = w_addr + AW'(w_k);
    assign mem_we      = !RST && (w_state == W_DATA) && wvalid && wready && !w_dec;

    assign r_k_nxt   = r_k + 9'd1;
    assign r_idx     = r_addr + AW'(r_k);
    assign r_idx_nxt = r_addr + AW'(r_k_nxt);

    assign b_err_fire = (w_state == W_RESP) && bvalid && bready && (bresp != RESP_OKAY);
    assign r_err_fire = (r_state == R_DATA) && rvalid && rready && rlast && (rresp != RESP_OKAY);

    assign busy = (w_state != W_IDLE) || (r_state != R_IDLE);

    // Write FSM: one outstanding write; accept AW, then beats, then hold B.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        bid     <= awid;
                        w_addr  <= awaddr[AW-1:0];
                        w_beats <= {1'b0, awlen} + 9'd1;
                        w_k     <= 9'd0;
                        w_dec   <= burst_decerr(awaddr, awlen);
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        w_k <= w_k + 9'd1;
                        // an early wlast or a missing one both close the burst
                        if (w_last_beat || wlast) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            if (w_dec)
                                bresp <= RESP_DECERR;
                            else if (wlast != w_last_beat)
                                bresp <= RESP_SLVERR;
                            else
                                bresp <= RESP_OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we)
            mem[w_idx] <= wdata;
    end

    // Read FSM: AR, READ_DELAY idle cycles, then beats loaded one per handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rid     <= arid;
                        r_addr  <= araddr[AW-1:0];
                        r_beats <= {1'b0, arlen} + 9'd1;
                        r_k     <= 9'd0;
                        r_dec   <= burst_decerr(araddr, arlen);
                        if (READ_DELAY == 0) begin
                            r_state <= R_DATA;
                        end else begin
                            r_wait  <= 32'(READ_DELAY - 1);
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_wait == 32'd0)
                        r_state <= R_DATA;
                    else
                        r_wait <= r_wait - 32'd1;
                end
                R_DATA: begin
                    // first entry loads beat 0; afterwards each handshake loads the next
                    if (!rvalid) begin
                        rvalid <= 1'b1;
                        rdata  <= r_dec ? '0 : mem[r_idx];
                        rresp  <= r_dec ? RESP_DECERR : RESP_OKAY;
                        rlast  <= (r_k == (r_beats - 9'd1));
                    end else if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_k   <= r_k_nxt;
                            rdata <= r_dec ? '0 : mem[r_idx_nxt];
                            rlast <= (r_k_nxt == (r_beats - 9'd1));
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Error counter: one per non-OKAY burst response, saturating at 255.
    always_ff @(posedge CLK) begin
        if (RST)
            err_count <= 8'd0;
        else
            err_count <= err_sat_add(err_count, b_err_fire, r_err_fire);
    end

endmodule

// File: tb/tb_axi4_burst_mem_responder.sv
// Directed bench for axi4_burst_mem_responder: bursts, backpressure, error
// responses and reset in the middle of a read.
module tb_axi4_burst_mem_responder;

    localparam int DEPTH      = 256;
    localparam int READ_DELAY = 2;
    localparam int ID_W       = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  awid, arid, bid, rid;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic        awvalid, awready, wlast, wvalid, wready;
    logic [63:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rlast, rvalid, rready;
    logic [7:0]  err_count;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];

    always #5 clk = ~clk;

    axi4_burst_mem_responder #(
        .DEPTH(DEPTH), .READ_DELAY(READ_DELAY), .ID_W(ID_W), .DATA_W(64)
    ) dut (
        .CLK(clk), .RST(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_count(err_count), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one write burst; lat counts edges after the last W handshake
    // until bvalid is seen (0 means bvalid rose on the cycle right after it).
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input int nbeats, input int wlast_at, input logic [63:0] base,
                             output logic [1:0] resp, output logic [3:0] id_o, output int lat);
        bit hs;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin hs = awready; tick(); end
        awvalid = 1'b0;
        if (!hs) begin n_cmp++; n_bad++; $display("FAIL aw_handshake: timed out, need awready=1"); end
        for (int b = 0; b < nbeats; b++) begin
            wdata = base + 64'(b); wlast = (b == wlast_at); wvalid = 1'b1;
            hs = 1'b0;
            for (int t = 0; t < 50 && !hs; t++) begin hs = wready; tick(); end
            if (!hs) begin n_cmp++; n_bad++; $display("FAIL w_handshake: beat %0d timed out, need wready=1", b); end
        end
        wvalid = 1'b0; wlast = 1'b0;
        lat = 0;
        while (!bvalid && lat < 50) begin tick(); lat++; end
        resp = bresp; id_o = bid;
        tick();
    endtask

    // Drives one read burst, logging beats into rd_* and counting any change
    // of rdata/rlast/rvalid across a stalled cycle.
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input bit toggle, output int lat, output int got, output int cycles,
                            output int stall_bad, output logic rv_after);
        bit hs;
        logic [63:0] d;
        logic l;
        int n;
        n = int'(len) + 1;
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        hs = 1'b0;
        for (int t = 0; t < 50 && !hs; t++) begin hs = arready; tick(); end
        arvalid = 1'b0;
        if (!hs) begin n_cmp++; n_bad++; $display("FAIL ar_handshake: timed out, need arready=1"); end
        lat = 0;
        while (!rvalid && lat < 50) begin tick(); lat++; end
        got = 0; cycles = 0; stall_bad = 0;
        while (got < n && cycles < 200) begin
            rready = toggle ? (cycles % 2 == 0) : 1'b1;
            if (rvalid && rready) begin
                if (got < 16) begin
                    rd_data[got] = rdata; rd_resp[got] = rresp; rd_last[got] = rlast; rd_id[got] = rid;
                end
                got++;
                tick();
            end else if (rvalid) begin
                d = rdata; l = rlast;
                tick();
                if (rvalid !== 1'b1 || rdata !== d || rlast !== l) stall_bad++;
            end else begin
                tick();
            end
            cycles++;
        end
        rready = 1'b0;
        rv_after = rvalid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (awready !== 1'b0) begin n_bad++; $display("FAIL reset_awready: got %b need 0", awready); end
        n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL reset_wready: got %b need 0", wready); end
        n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL reset_bvalid: got %b need 0", bvalid); end
        n_cmp++; if (arready !== 1'b0) begin n_bad++; $display("FAIL reset_arready: got %b need 0", arready); end
        n_cmp++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin n_bad++; $display("FAIL reset_r: rvalid=%b rlast=%b need 0/0", rvalid, rlast); end
        n_cmp++; if (bresp !== 2'b00 || rresp !== 2'b00) begin n_bad++; $display("FAIL reset_resp: bresp=%0d rresp=%0d need 0/0", bresp, rresp); end
        n_cmp++; if (rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h need 0", rdata); end
        n_cmp++; if (err_count !== 8'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL reset_status: err=%0d busy=%b need 0/0", err_count, busy); end
        rst = 1'b0;
        tick();
        n_cmp++; if (awready !== 1'b1 || arready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: aw=%b ar=%b need 1/1", awready, arready); end
    endtask

    task automatic test_write_burst();
        logic [1:0] resp; logic [3:0] id_o; int lat;
        axi_write(32'd2, 8'd7, 4'd5, 8, 7, 64'hdeadbeefdeadbeef, resp, id_o, lat);
        n_cmp++; if (lat !== 0) begin n_bad++; $display("FAIL wr_b_latency: got %0d extra cycles need 0", lat); end
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL wr_bresp: got %0d need 0", resp); end
        n_cmp++; if (id_o !== 4'd5) begin n_bad++; $display("FAIL wr_bid: got %0d need 5", id_o); end
        n_cmp++; if (err_count !== 8'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL wr_status: err=%0d busy=%b need 0/0", err_count, busy); end
    endtask

    task automatic test_read_burst();
        int lat, got, cycles, sb; logic rva;
        axi_read(32'd2, 8'd7, 4'd9, 1'b0, lat, got, cycles, sb, rva);
        n_cmp++; if (lat !== READ_DELAY + 1) begin n_bad++; $display("FAIL rd_latency: got %0d need %0d", lat, READ_DELAY + 1); end
        n_cmp++; if (got !== 8 || cycles !== 8) begin n_bad++; $display("FAIL rd_beats: got %0d beats in %0d cycles need 8 in 8", got, cycles); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rd_data[i] !== 64'hdeadbeefdeadbeef + 64'(i) || rd_last[i] !== (i == 7) ||
                rd_resp[i] !== 2'b00 || rd_id[i] !== 4'd9) begin
                n_bad++;
                $display("FAIL rd_beat%0d: data=%h last=%b resp=%0d id=%0d need %h %b 0 9",
                         i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], 64'hdeadbeefdeadbeef + 64'(i), (i == 7));
            end
        end
        n_cmp++; if (rva !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rd_end: rvalid=%b busy=%b need 0/0", rva, busy); end
    endtask

    task automatic test_read_backpressure();
        int lat, got, cycles, sb; logic rva;
        axi_read(32'd2, 8'd7, 4'd1, 1'b1, lat, got, cycles, sb, rva);
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL bp_beats: got %0d need 8", got); end
        n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL bp_stable: %0d stalls changed outputs need 0", sb); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rd_data[i] !== 64'hdeadbeefdeadbeef + 64'(i) || rd_last[i] !== (i == 7)) begin
                n_bad++;
                $display("FAIL bp_beat%0d: data=%h last=%b need %h %b", i, rd_data[i], rd_last[i],
                         64'hdeadbeefdeadbeef + 64'(i), (i == 7));
            end
        end
    endtask

    task automatic test_decode_error();
        logic [1:0] resp; logic [3:0] id_o; int lat, got, cycles, sb; logic rva;
        axi_write(32'd254, 8'd1, 4'd2, 2, 1, 64'h1111111111111111, resp, id_o, lat);
        n_cmp++; if (resp !== 2'b00) begin n_bad++; $display("FAIL dec_prewrite: bresp=%0d need 0", resp); end
        axi_write(32'(DEPTH - 2), 8'd3, 4'd3, 4, 3, 64'h9999999999999999, resp, id_o, lat);
        n_cmp++; if (resp !== 2'b11 || id_o !== 4'd3) begin n_bad++; $display("FAIL dec_wr_bresp: bresp=%0d bid=%0d need 3/3", resp, id_o); end
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL dec_wr_err: got %0d need 1", err_count); end
        axi_read(32'd254, 8'd1, 4'd4, 1'b0, lat, got, cycles, sb, rva);
        n_cmp++; if (rd_data[0] !== 64'h1111111111111111 || rd_data[1] !== 64'h1111111111111112)
            begin n_bad++; $display("FAIL dec_mem_kept: %h %h need 1111111111111111 1111111111111112", rd_data[0], rd_data[1]); end
        axi_read(32'(DEPTH - 1), 8'd1, 4'd6, 1'b0, lat, got, cycles, sb, rva);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (rd_data[i] !== 64'd0 || rd_resp[i] !== 2'b11 || rd_last[i] !== (i == 1)) begin
                n_bad++; $display("FAIL dec_rd_beat%0d: data=%h resp=%0d last=%b need 0 3 %b", i, rd_data[i], rd_resp[i], rd_last[i], (i == 1));
            end
        end
        n_cmp++; if (err_count !== 8'd2) begin n_bad++; $display("FAIL dec_rd_err: got %0d need 2", err_count); end
    endtask

    task automatic test_protocol_error();
        logic [1:0] resp; logic [3:0] id_o; int lat, got, cycles, sb; logic rva;
        axi_write(32'd20, 8'd3, 4'd0, 4, 3, 64'h5555555555555550, resp, id_o, lat);
        axi_write(32'd20, 8'd3, 4'd7, 2, 1, 64'h00000000000000a0, resp, id_o, lat);
        n_cmp++; if (resp !== 2'b10) begin n_bad++; $display("FAIL early_wlast_bresp: got %0d need 2", resp); end
        n_cmp++; if (err_count !== 8'd3) begin n_bad++; $display("FAIL early_wlast_err: got %0d need 3", err_count); end
        axi_read(32'd20, 8'd3, 4'd0, 1'b0, lat, got, cycles, sb, rva);
        n_cmp++; if (rd_data[0] !== 64'ha0 || rd_data[1] !== 64'ha1 ||
                     rd_data[2] !== 64'h5555555555555552 || rd_data[3] !== 64'h5555555555555553) begin
            n_bad++; $display("FAIL early_wlast_mem: %h %h %h %h need a0 a1 5555555555555552 5555555555555553",
                              rd_data[0], rd_data[1], rd_data[2], rd_data[3]);
        end
        axi_write(32'd30, 8'd1, 4'd8, 2, -1, 64'h00000000000000b0, resp, id_o, lat);
        n_cmp++; if (resp !== 2'b10) begin n_bad++; $display("FAIL no_wlast_bresp: got %0d need 2", resp); end
        n_cmp++; if (err_count !== 8'd4) begin n_bad++; $display("FAIL no_wlast_err: got %0d need 4", err_count); end
        axi_read(32'd30, 8'd1, 4'd0, 1'b0, lat, got, cycles, sb, rva);
        n_cmp++; if (rd_data[0] !== 64'hb0 || rd_data[1] !== 64'hb1) begin
            n_bad++; $display("FAIL no_wlast_mem: %h %h need b0 b1", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        int got, t, lat, cycles, sb; logic rva;
        araddr = 32'd2; arlen = 8'd7; arid = 4'd3; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin tick(); t++; end
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        got = 0; t = 0;
        while (got < 3 && t < 50) begin
            if (rvalid) got++;
            tick(); t++;
        end
        rready = 1'b0;
        n_cmp++; if (rvalid !== 1'b1 || busy !== 1'b1 || rdata !== 64'hdeadbeefdeadbeef + 64'd3) begin
            n_bad++; $display("FAIL mid_beat3: rvalid=%b busy=%b data=%h need 1 1 deadbeefdeadbef2", rvalid, busy, rdata);
        end
        rst = 1'b1;
        tick();
        n_cmp++; if (rvalid !== 1'b0 || arready !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: rvalid=%b arready=%b busy=%b need 0 0 0", rvalid, arready, busy);
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (arready !== 1'b1 || err_count !== 8'd0) begin
            n_bad++; $display("FAIL post_reset: arready=%b err=%0d need 1/0", arready, err_count);
        end
        axi_read(32'd2, 8'd7, 4'd2, 1'b0, lat, got, cycles, sb, rva);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (rd_data[i] !== 64'hdeadbeefdeadbeef + 64'(i)) begin
                n_bad++; $display("FAIL post_reset_mem%0d: got %h need %h", i, rd_data[i], 64'hdeadbeefdeadbeef + 64'(i));
            end
        end
    endtask

    task automatic test_single_beat();
        int lat, got, cycles, sb; logic rva;
        axi_read(32'd20, 8'd0, 4'd12, 1'b0, lat, got, cycles, sb, rva);
        n_cmp++; if (lat !== READ_DELAY + 1 || got !== 1) begin n_bad++; $display("FAIL single_timing: lat=%0d beats=%0d need %0d/1", lat, got, READ_DELAY + 1); end
        n_cmp++; if (rd_data[0] !== 64'ha0 || rd_last[0] !== 1'b1 || rd_id[0] !== 4'd12) begin
            n_bad++; $display("FAIL single_beat: data=%h last=%b id=%0d need a0 1 12", rd_data[0], rd_last[0], rd_id[0]);
        end
        n_cmp++; if (rva !== 1'b0 || err_count !== 8'd0) begin n_bad++; $display("FAIL single_end: rvalid=%b err=%0d need 0/0", rva, err_count); end
    endtask

    initial begin
        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_backpressure();
        test_decode_error();
        test_protocol_error();
        test_reset_mid_burst();
        test_single_beat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
